// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline MEM stage.
//   WORD_W       datapath width
//   REG_ADDR_W   register-file address width
//   mem_state_t  MEM-stage bus FSM states
//   word_addr()  clears the byte offset of an address
package mips_pipe_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM stage (master) and data memory (slave).
//   dmem_req    request, held until ack
//   dmem_we     1=store, 0=load; valid while dmem_req
//   dmem_addr   word address; valid while dmem_req
//   dmem_wdata  store data; valid while dmem_req
//   dmem_rdata  load data, sampled in the ack cycle
//   dmem_ack    single-cycle completion pulse
interface mem_stage_ctrl_if;
    import mips_pipe_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [WORD_W-1:0] dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/mem_stage_ctrl_memwb_reg.sv
// MEM/WB pipeline register.
//   clk, rst         clock, async active-high reset (clears everything)
//   load_en          capture next_* this edge; when low, insert a bubble
//   bubble           when loading, force wb_regwrite to 0 (killed instruction)
//   rdata_en         when loading, also capture next_read_data
//   next_*           values from the MEM stage
//   wb_*             registered outputs feeding write-back and forwarding
module memwb_reg
    import mips_pipe_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  bubble,
    input  logic                  rdata_en,
    input  logic                  next_regwrite,
    input  logic                  next_memtoreg,
    input  logic [WORD_W-1:0]     next_read_data,
    input  logic [WORD_W-1:0]     next_alu_result,
    input  logic [REG_ADDR_W-1:0] next_rd,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [WORD_W-1:0]     wb_read_data,
    output logic [WORD_W-1:0]     wb_alu_result,
    output logic [REG_ADDR_W-1:0] wb_rd
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_regwrite   <= 1'b0;
            wb_memtoreg   <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_rd         <= '0;
        end else if (!load_en) begin
            // Stalled: downstream sees a bubble, payload holds.
            wb_regwrite <= 1'b0;
        end else begin
            wb_regwrite   <= next_regwrite & ~bubble;
            wb_memtoreg   <= next_memtoreg;
            wb_alu_result <= next_alu_result;
            wb_rd         <= next_rd;
            if (rdata_en) begin
                wb_read_data <= next_read_data;
            end
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MIPS pipeline MEM stage: issues loads/stores on a variable-latency req/ack
// data-memory bus, stalls upstream until completion, and owns MEM/WB.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned ops are killed and
// reported on align_err instead of reaching the bus).
//   clk, rst         clock, async active-high reset
//   ex_*             EX/MEM register outputs
//   dmem             data-memory bus (master side)
//   mem_stall        freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//   bus_err          sticky memory-timeout flag
//   wb_*             MEM/WB register outputs
//   align_err        (MEM_ALIGN_CHECK_EN only) one-cycle misalignment pulse
module mem_stage_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_regwrite,
    input  logic                  ex_memwrite,
    input  logic                  ex_memread,
    input  logic                  ex_memtoreg,
    input  logic [WORD_W-1:0]     ex_alu_result,
    input  logic [WORD_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    mem_stage_ctrl_if.master      dmem,
    output logic                  mem_stall,
    output logic                  bus_err,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [WORD_W-1:0]     wb_read_data,
    output logic [WORD_W-1:0]     wb_alu_result,
    output logic [REG_ADDR_W-1:0] wb_rd
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic                  align_err
`endif
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              req_q;
    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              bus_err_q;

    logic mem_op;
    logic mem_go;
    logic kill;
    logic in_wait;
    logic timeout;
    logic done;
    logic is_load;

    assign mem_op  = ex_memread | ex_memwrite;
    // Read+write together is a store.
    assign is_load = ex_memread & ~ex_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    logic align_err_q;

    assign misaligned = mem_op & (ex_alu_result[1:0] != 2'b00);
    assign mem_go     = mem_op & ~misaligned;
    assign kill       = timeout | misaligned;
`else
    assign mem_go     = mem_op;
    assign kill       = timeout;
`endif

    assign in_wait = (state == WAIT);
    // Ack on the last allowed cycle still counts as a completion.
    assign timeout = in_wait & ~dmem.dmem_ack & (cnt == CNT_LAST);
    assign done    = in_wait & (dmem.dmem_ack | timeout);

    // Gated by rst so an asynchronous reset releases the pipeline at once.
    assign mem_stall = ~rst & mem_go & ~done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_go) begin
                        state   <= WAIT;
                        cnt     <= '0;
                        req_q   <= 1'b1;
                        we_q    <= ex_memwrite;
                        addr_q  <= word_addr(ex_alu_result);
                        wdata_q <= ex_store_data;
                    end
                end
                WAIT: begin
                    if (dmem.dmem_ack) begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        req_q     <= 1'b0;
                        bus_err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // A misaligned op never stalls, so this is naturally a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= misaligned & ~in_wait;
        end
    end

    assign align_err = align_err_q;
`endif

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign bus_err         = bus_err_q;

    memwb_reg u_memwb_reg (
        .clk             (clk),
        .rst             (rst),
        .load_en         (~mem_stall),
        .bubble          (kill),
        .rdata_en        (is_load & in_wait & dmem.dmem_ack),
        .next_regwrite   (ex_regwrite),
        .next_memtoreg   (ex_memtoreg),
        .next_read_data  (dmem.dmem_rdata),
        .next_alu_result (ex_alu_result),
        .next_rd         (ex_rd),
        .wb_regwrite     (wb_regwrite),
        .wb_memtoreg     (wb_memtoreg),
        .wb_read_data    (wb_read_data),
        .wb_alu_result   (wb_alu_result),
        .wb_rd           (wb_rd)
    );

endmodule
